// File: rtl/md_hazard_ctrl_pkg.sv
// rtl/md_hazard_ctrl_pkg.sv - shared multiply/divide state encoding and default latencies
package md_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MD_CNT_W       = 4;
  localparam int MD_CNT_MAX     = 15;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_hazard_ctrl.sv
// rtl/md_hazard_ctrl.sv - multiply/divide hazard controller: busy model, stall, HI/LO commit
module md_hazard_ctrl
  import md_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                D_md_use,
  input  logic                E_start,
  input  logic                E_is_div,
  input  logic                XALU_Busy,
  output logic                stall,
  output logic                md_busy,
  output logic                hilo_commit,
  output logic [MD_CNT_W-1:0] cnt,
  output logic [31:0]         stall_cycles,
  output logic                err_overlap,
  output logic                err_mismatch
);

  // A latency of 0 would leave BUSY with nothing to count down; >15 overflows cnt.
  if (MULT_CYCLES < 1 || MULT_CYCLES > MD_CNT_MAX ||
      DIV_CYCLES < 1 || DIV_CYCLES > MD_CNT_MAX) begin : g_bad_params
    $error("md_hazard_ctrl: MULT_CYCLES and DIV_CYCLES must be within 1..15");
  end

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           busy_q, busy_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic                err_overlap_q, err_overlap_d;
  logic                err_mismatch_q, err_mismatch_d;
  logic                in_busy;

  assign in_busy = (busy_q == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q         <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      err_overlap_q  <= 1'b0;
      err_mismatch_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      err_overlap_q  <= err_overlap_d;
      err_mismatch_q <= err_mismatch_d;
    end
  end

  always_comb begin
    busy_d         = busy_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q + 32'(stall);
    // A start while busy is dropped; only the sticky flag records it.
    err_overlap_d  = err_overlap_q | (E_start & in_busy);
    err_mismatch_d = err_mismatch_q | (md_busy != XALU_Busy);
    case (busy_q)
      IDLE: begin
        if (E_start) begin
          busy_d = BUSY;
          cnt_d  = E_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q > MD_CNT_W'(1)) begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end else begin
          busy_d = IDLE;
          cnt_d  = '0;
        end
      end
      default: begin
        busy_d = IDLE;
        cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    md_busy     = E_start | in_busy;
    stall       = D_md_use & md_busy;
    hilo_commit = in_busy & (cnt_q == MD_CNT_W'(1));
  end

  assign cnt          = cnt_q;
  assign stall_cycles = stall_cycles_q;
  assign err_overlap  = err_overlap_q;
  assign err_mismatch = err_mismatch_q;

endmodule

// File: doc/md_hazard_ctrl.md
MD_HAZARD_CTRL -- requirements
Module: md_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles after a mult/multu issue edge.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles after a div/divu issue edge.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port D_md_use, input, 1 bit: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-006 SHALL have port E_start, input, 1 bit: E-stage instruction is mult/multu/div/divu this cycle.
REQ-007 SHALL have port E_is_div, input, 1 bit: qualifies E_start (1 = div/divu, 0 = mult/multu).
REQ-008 SHALL have port XALU_Busy, input, 1 bit: busy output of the multiply/divide unit, used for cross-check.
REQ-009 SHALL have port stall, output, 1 bit: freezes F/D and inserts an E bubble.
REQ-010 SHALL have port md_busy, output, 1 bit: model of multiply/divide busy, equal to E_start | busy_q.
REQ-011 SHALL have port hilo_commit, output, 1 bit: one-cycle pulse in the cycle whose rising edge writes HI/LO.
REQ-012 SHALL have port cnt, output, 4 bits: remaining busy cycles.
REQ-013 SHALL have port stall_cycles, output, 32 bits: performance counter of stalled cycles.
REQ-014 SHALL have port err_overlap, output, 1 bit: sticky; E_start arrived while busy_q = 1.
REQ-015 SHALL have port err_mismatch, output, 1 bit: sticky; md_busy != XALU_Busy.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and BUSY, held in register busy_q.
REQ-017 In IDLE with E_start = 1, SHALL load cnt with DIV_CYCLES if E_is_div, otherwise with MULT_CYCLES, and enter BUSY at that edge.
REQ-018 In BUSY with cnt > 1, SHALL decrement cnt by 1 each cycle.
REQ-019 In BUSY with cnt == 1, SHALL assert hilo_commit combinationally, set cnt to 0 and return to IDLE at that edge.
REQ-020 SHALL make the total stall window for an issue equal to N+1 cycles (the issue cycle plus N BUSY cycles), where N is the loaded value.
REQ-021 SHALL drive stall = D_md_use & md_busy, purely combinational, so that it applies in the issue cycle.
REQ-022 SHALL force stall = 0 whenever D_md_use = 0, whatever the busy state.
REQ-023 SHALL handle E_start while busy_q = 1 as follows: set err_overlap, ignore the start, and leave cnt unchanged.
REQ-024 SHALL treat E_start in the same cycle as cnt == 1 as an overlap: set err_overlap, commit normally and return to IDLE.
REQ-025 SHALL increment stall_cycles by 1 on every edge where stall = 1, with 32-bit wrap-around from 0xFFFFFFFF to 0.
REQ-026 SHALL set err_mismatch on any non-reset edge where md_busy != XALU_Busy; once set it holds until reset.
REQ-027 SHALL never let cnt underflow below 0 or exceed 15; parameters above 15 are illegal and SHALL be rejected at elaboration.
REQ-028 SHALL ignore E_is_div when E_start = 0.

Reset
REQ-029 On a rising clk edge with reset = 1, SHALL clear busy_q, cnt, stall_cycles, err_overlap and err_mismatch to 0.
REQ-030 Reset SHALL take priority over E_start and any in-flight countdown; a reset mid-operation abandons it with no hilo_commit pulse.
REQ-031 Out of reset, the outputs SHALL read stall = D_md_use & E_start, hilo_commit = 0 and md_busy = E_start.

Structure
REQ-032 SHALL place the state encoding (IDLE/BUSY) and the default latency constants (MULT_CYCLES, DIV_CYCLES) in the shared package already included by the multiply/divide unit.
REQ-033 SHALL be implemented as a single flat module with no sub-modules.
REQ-034 SHALL contain no memories and no multi-cycle combinational paths.

Verification
REQ-035 Mult issue: E_start = 1, E_is_div = 0 at cycle 0 -> md_busy = 1 in cycles 0-5; cnt reads 5,4,3,2,1 in cycles 1-5; hilo_commit = 1 in cycle 5 only; cycle 6 is IDLE.
REQ-036 Div followed by mflo: div issued at cycle 0, D_md_use = 1 held -> stall = 1 in cycles 0-10; stall_cycles = 11; stall = 0 in cycle 11.
REQ-037 Overlap: mult at cycle 0, E_start = 1 again at cycle 2 -> err_overlap = 1 from cycle 3; cnt sequence unchanged; hilo_commit at cycle 5.
REQ-038 Reset mid-div: div at cycle 0, reset = 1 in cycle 4 -> cnt = 0, md_busy = 0 from cycle 5; no hilo_commit pulse; counters cleared.
REQ-039 Cross-check: XALU_Busy forced to 0 in cycle 3 of a mult -> err_mismatch = 1 from cycle 4 and stays set until reset.
REQ-040 Non-MD traffic: D_md_use = 0 throughout a div -> stall = 0 in every cycle; stall_cycles unchanged.
